uart_tx_slv: RTL and testbench
==============================

// Module: uart_tx_slv
// PURPOSE
//  Memory-mapped UART transmitter; responder (slave) end of the mem_req_t/mem_resp_t valid/ready bus.
//  Attaches to a free mem_noc_router_1to4 slave port (sn2).
//  Software writes bytes into a TX FIFO; an 8N1 serializer drains them on uart_tx at a programmable divisor.
//  Provides status readback and a level interrupt.
// PARAMETERS
//  FIFO_DEPTH   8       TX FIFO entries; power of 2, >=2
//  DIV_RST      16'd434 reset value of DIV (clk cycles per bit)
//  ADDR_LSB_W   4       address bits decoded: addr[3:2] selects register
// PORTS
//  clk             in   1           core clock
//  rstn            in   1           async active-low reset
//  mem_req_valid   in   1           request valid
//  mem_req_ready   out  1           request accepted when valid&&ready
//  mem_req         in   mem_req_t   addr, wdata, wstrb (wstrb!=0 => write, else read)
//  mem_resp_valid  out  1           response valid
//  mem_resp_ready  in   1           response consumed when valid&&ready
//  mem_resp        out  mem_resp_t  rdata (32b)
//  uart_tx         out  1           serial line, idle high
//  tx_irq          out  1           level: FIFO empty && IRQ_EN
// BEHAVIOUR
//  Reset (rstn low, async): mem_req_ready=1, mem_resp_valid=0, rdata=0, uart_tx=1, tx_irq=0.
//   FIFO empty, FSM IDLE, DIV=DIV_RST, CTRL=0, OVF=0.
//  Bus handshake:
//   - One outstanding transaction: mem_req_ready = !mem_resp_valid.
//   - Accept at cycle N -> mem_resp_valid=1 at N+1.
//   - mem_resp held stable until mem_resp_ready; drops the cycle after handshake; ready returns at once.
//   - Writes return rdata=0.
//  Registers (addr[3:2]):
//   0 TXDATA  W: push wdata[7:0] if wstrb[0]; R: 0
//   1 STATUS  R: {27'b0, OVF, IRQ_PEND, TX_BUSY, FULL, EMPTY}; W 1 to bit4 clears OVF
//   2 DIV     R/W [15:0]; bytes honour wstrb[1:0]; DIV=0 treated as 1
//   3 CTRL    R/W [0]=IRQ_EN, [1]=TX_EN; upper bits read 0
//  FIFO push:
//   - Push to full FIFO: byte dropped, OVF set (sticky); response still returned normally.
//   - Push and pop in the same cycle with FIFO full: push succeeds.
//   - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally.
//  Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE/START
//   - IDLE: if TX_EN && !EMPTY, pop byte, go START.
//   - START: uart_tx=0.
//   - DATA: 8 bits LSB first.
//   - STOP: uart_tx=1; then START if TX_EN && !EMPTY (back-to-back, no idle bit), else IDLE.
//   - Each state/bit lasts max(DIV,1) clk cycles via down-counter reloaded at every bit boundary.
//   - DIV written mid-frame takes effect at the next bit boundary.
//   - TX_EN cleared mid-frame: current frame completes, no further pop.
//   - TX_BUSY = (state != IDLE).
//  tx_irq = IRQ_EN && EMPTY && !TX_BUSY; registered, one-cycle lag.
//  Reset mid-frame: uart_tx forced high immediately, FIFO contents lost.
//  Unused addr bits above ADDR_LSB_W ignored (router has already decoded base).
// TESTING
//  1 Reset, read STATUS -> rdata=0x1 (EMPTY); uart_tx=1; mem_resp_valid 1 cycle after accept.
//  2 DIV=4, CTRL=0x2, write TXDATA 0xA5 -> uart_tx: 0 for 4 clk, bits 1,0,1,0,0,1,0,1 (4 clk each), then 1.
//  3 Write 9 bytes with TX_EN=0, FIFO_DEPTH=8 -> STATUS=0x12 (FULL|OVF); write 0x10 to STATUS -> OVF=0.
//  4 Hold mem_resp_ready=0 for 5 cycles -> mem_resp stable, mem_req_ready=0 throughout; new request stalls.
//  5 CTRL=0x3, push 2 bytes -> frames back-to-back, no idle gap; tx_irq rises after final stop bit.
//  6 Assert rstn low mid DATA bit -> uart_tx=1 same cycle; after release STATUS=0x1, DIV=DIV_RST.

Source files
------------

// File: rtl/uart_tx_slv_if.sv
// Bus types and valid/ready request/response bundle for uart_tx_slv.
// The master drives requests; the slave answers with one response each.
package uart_tx_slv_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
   } mem_resp_t;
endpackage

interface uart_tx_slv_if;
   import uart_tx_slv_pkg::*;

   logic      mem_req_valid;
   logic      mem_req_ready;
   mem_req_t  mem_req;
   logic      mem_resp_valid;
   logic      mem_resp_ready;
   mem_resp_t mem_resp;

   modport master (
      output mem_req_valid,
      output mem_req,
      output mem_resp_ready,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req,
      input  mem_resp_ready,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp
   );
endinterface

// File: rtl/uart_tx_slv.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and level irq.
// Bus slave with one outstanding transaction.
module uart_tx_slv #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RST    = 16'd434,
   parameter int          ADDR_LSB_W = 4
) (
   input  logic         clk,
   input  logic         rstn,
   uart_tx_slv_if.slave bus,
   output logic         uart_tx,
   output logic         tx_irq
);
   import uart_tx_slv_pkg::*;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE, START, DATA, STOP
   } state_e;

   state_e      state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        ovf_q, ovf_d;
   logic        irq_q, irq_d;
   logic        tx_q, tx_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  fifo_q [FIFO_DEPTH];

   logic        acc, wr, empty, full;
   logic        push_req, push, pop;
   logic        busy, start_ok;
   logic        sel_tx, sel_st, sel_div, sel_ctl;
   logic [1:0]  sel;
   logic [15:0] reload;
   logic [31:0] rd_val;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        unused_bits;

   assign wdata = bus.mem_req.wdata;
   assign wstrb = bus.mem_req.wstrb;
   assign sel   = bus.mem_req.addr[ADDR_LSB_W-1 -: 2];

   assign sel_tx  = (sel == 2'd0);
   assign sel_st  = (sel == 2'd1);
   assign sel_div = (sel == 2'd2);
   assign sel_ctl = (sel == 2'd3);

   assign acc = bus.mem_req_valid && !resp_valid_q;
   assign wr  = |wstrb;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
               && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign busy     = (state_q != IDLE);
   assign start_ok = ctrl_q[1] && !empty;
   assign reload   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_req = acc && wr && sel_tx && wstrb[0];
   assign push     = push_req && (!full || pop);

   assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   assign bus.mem_req_ready  = !resp_valid_q;
   assign bus.mem_resp_valid = resp_valid_q;
   assign bus.mem_resp       = '{rdata: rdata_q};
   assign uart_tx            = tx_q;
   assign tx_irq             = irq_q;

   assign unused_bits = ^{bus.mem_req.addr[31:ADDR_LSB_W],
                          bus.mem_req.addr[1:0],
                          wdata[31:16]};

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel_st:  rd_val = {27'b0, ovf_q, irq_q,
                            busy, full, empty};
         sel_div: rd_val = {16'b0, div_q};
         sel_ctl: rd_val = {30'b0, ctrl_q};
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      div_d        = div_q;
      ctrl_d       = ctrl_q;
      ovf_d        = ovf_q;
      if (resp_valid_q && bus.mem_resp_ready) begin
         resp_valid_d = 1'b0;
      end
      if (acc) begin
         resp_valid_d = 1'b1;
         rdata_d      = wr ? 32'd0 : rd_val;
         if (wr) begin
            if (sel_st && wstrb[0] && wdata[4]) begin
               ovf_d = 1'b0;
            end
            if (sel_div && wstrb[0]) begin
               div_d[7:0] = wdata[7:0];
            end
            if (sel_div && wstrb[1]) begin
               div_d[15:8] = wdata[15:8];
            end
            if (sel_ctl && wstrb[0]) begin
               ctrl_d = wdata[1:0];
            end
         end
      end
      if (push_req && !push) begin
         ovf_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               pop     = 1'b1;
               shift_d = fifo_q[rd_ptr_q[AW-1:0]];
               cnt_d   = reload;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = reload;
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d = reload;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         STOP: begin
            if (cnt_q == 16'd0) begin
               if (start_ok) begin
                  pop     = 1'b1;
                  shift_d = fifo_q[rd_ptr_q[AW-1:0]];
                  cnt_d   = reload;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // line level follows the next state so it is glitch-free from a flop
      tx_d = 1'b1;
      if (state_d == START) begin
         tx_d = 1'b0;
      end else if (state_d == DATA) begin
         tx_d = shift_d[0];
      end
      irq_d = ctrl_q[0] && empty && (state_q == IDLE);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         div_q        <= DIV_RST;
         ctrl_q       <= '0;
         ovf_q        <= 1'b0;
         irq_q        <= 1'b0;
         tx_q         <= 1'b1;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         div_q        <= div_d;
         ctrl_q       <= ctrl_d;
         ovf_q        <= ovf_d;
         irq_q        <= irq_d;
         tx_q         <= tx_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_slv.sv
// Randomized bench for uart_tx_slv: bus register checks plus a line
// decoder compared against a byte-queue model of the FIFO.
module tb_uart_tx_slv;
   import uart_tx_slv_pkg::*;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_TXD = 32'h0;
   localparam logic [31:0] A_STA = 32'h4;
   localparam logic [31:0] A_DIV = 32'h8;
   localparam logic [31:0] A_CTL = 32'hC;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic uart_tx, tx_irq;

   uart_tx_slv_if bus();

   uart_tx_slv #(
      .FIFO_DEPTH(DEPTH),
      .DIV_RST(16'd434),
      .ADDR_LSB_W(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus.slave),
      .uart_tx(uart_tx),
      .tx_irq(tx_irq)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   logic [7:0] model_q[$];
   logic [15:0] div_m;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       output logic [31:0] r);
      int n;
      n = 0;
      @(negedge clk);
      bus.mem_req_valid  = 1'b1;
      bus.mem_req        = '{addr: a, wdata: d, wstrb: s};
      bus.mem_resp_ready = 1'b1;
      while (bus.mem_req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_timeout", 1, 0);
      @(posedge clk);
      #1 bus.mem_req_valid = 1'b0;
      @(negedge clk);
      check("resp_lat", bus.mem_resp_valid, 1);
      r = bus.mem_resp.rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s);
      logic [31:0] r;
      xfer(a, d, s, r);
      check("wr_rdata0", r, 0);
   endtask

   task automatic rd(input logic [31:0] a,
                     output logic [31:0] r);
      xfer(a, 32'h0, 4'h0, r);
   endtask

   task automatic push_m(input logic [7:0] b);
      wr(A_TXD, {24'h0, b}, 4'h1);
   endtask

   task automatic rx_frame(input int div,
                           output logic [7:0] b,
                           output bit clean,
                           output int waits);
      logic [9:0] bits;
      waits = 0;
      clean = 1'b1;
      b = 8'h0;
      bits = '0;
      @(negedge clk);
      while (uart_tx !== 1'b0 && waits < 500) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 500) begin
         waits = -1;
         clean = 1'b0;
         return;
      end
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < div; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (c == 0) bits[k] = uart_tx;
            else if (uart_tx !== bits[k]) clean = 1'b0;
         end
      end
      b = bits[8:1];
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) clean = 1'b0;
   endtask

   task automatic rx_expect(input int div,
                            input bit b2b,
                            input string tag);
      logic [7:0] b, e;
      bit cl;
      int w;
      rx_frame(div, b, cl, w);
      e = (model_q.size() > 0) ? model_q.pop_front() : 8'hxx;
      check({tag, "_byte"}, b, e);
      check({tag, "_clean"}, cl, 1);
      if (b2b) check({tag, "_b2b"}, w, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [7:0] b;
      int d, de;
      bit ok, ovf_m;

      bus.mem_req_valid  = 1'b0;
      bus.mem_req        = '0;
      bus.mem_resp_ready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready", bus.mem_req_ready, 1);
      check("rst_rvalid", bus.mem_resp_valid, 0);
      check("rst_rdata", bus.mem_resp.rdata, 0);
      check("rst_tx", uart_tx, 1);
      check("rst_irq", tx_irq, 0);
      rstn = 1'b1;
      rd(A_STA, r); check("t1_status", r, 32'h1);
      rd(A_DIV, r); check("t1_div", r, 434);
      rd(A_CTL, r); check("t1_ctrl", r, 0);
      rd(A_TXD, r); check("t1_txd_rd", r, 0);
      div_m = 16'd434;

      // strobes, CTRL width, non-push write, alias addr
      wr(A_DIV, 32'h1234, 4'hF);
      wr(A_DIV, 32'hFF77, 4'h1);
      rd(A_DIV, r); check("div_strb", r, 32'h1277);
      wr(A_CTL, 32'hFFFF_FFF0, 4'hF);
      rd(A_CTL, r); check("ctrl_upper", r, 0);
      wr(A_TXD, 32'h55, 4'h2);
      rd(32'hFFFF_F004, r); check("no_push_alias", r, 32'h1);

      // single frame, DIV=4
      wr(A_DIV, 4, 4'h3);
      div_m = 16'd4;
      wr(A_CTL, 32'h2, 4'h1);
      model_q.push_back(8'hA5);
      push_m(8'hA5);
      rx_expect(4, 1'b0, "t2");
      @(negedge clk); check("t2_idle", uart_tx, 1);

      // overflow with TX disabled
      wr(A_CTL, 0, 4'h1);
      ovf_m = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         if (model_q.size() < DEPTH) model_q.push_back(b);
         else ovf_m = 1'b1;
         push_m(b);
      end
      rd(A_STA, r);
      check("t3_status", r, {27'b0, ovf_m, 1'b0, 1'b0,
            model_q.size() == DEPTH, model_q.size() == 0});
      wr(A_STA, 32'h10, 4'h1);
      rd(A_STA, r); check("t3_ovf_clr", r, 32'h2);

      // drain at random DIV including 0
      d = $urandom_range(0, 3);
      de = (d == 0) ? 1 : d;
      wr(A_DIV, d, 4'h3);
      div_m = 16'(d);
      rd(A_DIV, r); check("t3_div_rd", r, d);
      wr(A_CTL, 32'h2, 4'h1);
      for (int i = 0; i < DEPTH; i++) rx_expect(de, i > 0, "t3");
      @(negedge clk); check("t3_idle", uart_tx, 1);
      rd(A_STA, r); check("t3_empty", r, 32'h1);

      // response back-pressure
      @(negedge clk);
      bus.mem_req_valid  = 1'b1;
      bus.mem_req        = '{addr: A_STA, wdata: 0, wstrb: 0};
      bus.mem_resp_ready = 1'b0;
      @(posedge clk);
      #1 bus.mem_req = '{addr: A_DIV, wdata: 0, wstrb: 0};
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.mem_resp_valid !== 1'b1 ||
             bus.mem_resp.rdata !== 32'h1 ||
             bus.mem_req_ready !== 1'b0) ok = 1'b0;
      end
      check("t4_hold", ok, 1);
      bus.mem_resp_ready = 1'b1;
      @(negedge clk);
      check("t4_drop", bus.mem_resp_valid, 0);
      check("t4_ready", bus.mem_req_ready, 1);
      @(posedge clk);
      #1 bus.mem_req_valid = 1'b0;
      @(negedge clk);
      check("t4_stall_valid", bus.mem_resp_valid, 1);
      check("t4_stall_rdata", bus.mem_resp.rdata, div_m);
      @(posedge clk);
      #1;

      // back-to-back frames and irq
      d = $urandom_range(2, 5);
      wr(A_DIV, d, 4'h3);
      wr(A_CTL, 32'h3, 4'h1);
      rd(32'h0000_0104, r); check("t5_irq_pend", r, 32'h9);
      check("t5_irq_hi", tx_irq, 1);
      for (int i = 0; i < 2; i++) model_q.push_back(8'($urandom));
      fork
         begin
            push_m(model_q[0]);
            push_m(model_q[1]);
         end
         begin
            rx_expect(d, 1'b0, "t5a");
            rx_expect(d, 1'b1, "t5b");
            @(negedge clk); check("t5_irq_lag", tx_irq, 0);
            @(negedge clk); check("t5_irq_rise", tx_irq, 1);
         end
      join

      // reset in the middle of a data bit
      wr(A_CTL, 0, 4'h1);
      wr(A_DIV, 8, 4'h3);
      for (int i = 0; i < 3; i++) push_m(8'h00);
      wr(A_CTL, 32'h2, 4'h1);
      d = 0;
      while (uart_tx !== 1'b0 && d < 100) begin
         @(negedge clk);
         d++;
      end
      repeat (8 + 3) @(negedge clk);
      check("t6_pre_low", uart_tx, 0);
      rstn = 1'b0;
      #1;
      check("t6_tx_hi", uart_tx, 1);
      check("t6_rvalid", bus.mem_resp_valid, 0);
      check("t6_ready", bus.mem_req_ready, 1);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      rd(A_STA, r); check("t6_status", r, 32'h1);
      rd(A_DIV, r); check("t6_div", r, 434);
      rd(A_CTL, r); check("t6_ctrl", r, 0);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) ok = 1'b0;
      end
      check("t6_line_idle", ok, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
